// File: rtl/control_sequencer.sv
// Multicycle fetch/decode/execute controller for the accumulator machine.
// Owns PC/IR/ACC and sequences MainMemory and the ALU every cycle.
module control_sequencer #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] acc,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOADIR = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  localparam logic [3:0]  OP_HALT  = 4'h0;
  localparam logic [3:0]  OP_LOAD  = 4'h1;
  localparam logic [3:0]  OP_STORE = 4'h2;
  localparam logic [3:0]  OP_JUMP  = 4'h3;
  localparam logic [3:0]  OP_JZ    = 4'h4;
  localparam logic [3:0]  OP_ALU   = 4'h8;
  localparam logic [3:0]  FN_DIV   = 4'b0011;
  localparam logic [15:0] PC_LAST  = 16'(MEM_WORDS - 1);

  state_e      state_q;
  logic [15:0] pc_q, ir_q, acc_q;
  logic        halted_q, illegal_q;

  logic [3:0]  op;
  logic [15:0] addr12, addr8, opnd_addr, pc_inc_d, alu_wb_d;

  assign op       = ir_q[15:12];
  assign addr12   = {4'h0, ir_q[11:0]};
  assign addr8    = {8'h00, ir_q[7:0]};
  assign opnd_addr = (op == OP_ALU) ? addr8 : addr12;
  assign pc_inc_d = (pc_q == PC_LAST) ? 16'h0000 : pc_q + 16'h0001;
  // Divide-style func with a zero divisor saturates instead of taking the ALU value.
  assign alu_wb_d = ((ir_q[11:8] == FN_DIV) && (mem_rdata == 16'h0000)) ? 16'hFFFF : alu_result;

  always_comb begin
    mem_addr = pc_q;
    if ((state_q == S_EXEC) && ((op == OP_LOAD) || (op == OP_STORE) || (op == OP_ALU)))
      mem_addr = opnd_addr;
  end

  assign mem_we     = (state_q == S_EXEC) && (op == OP_STORE);
  assign mem_wdata  = acc_q;
  assign alu_opcode = ir_q[11:8];
  assign alu_a      = acc_q;
  assign alu_b      = mem_rdata;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign acc        = acc_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign state      = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      acc_q     <= 16'h0000;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   if (run) state_q <= S_FETCH;
        S_FETCH:  state_q <= S_LOADIR;
        S_LOADIR: begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_inc_d;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_LOAD, OP_ALU: state_q <= S_WB;
            OP_STORE:        state_q <= S_FETCH;
            OP_JUMP: begin
              pc_q    <= addr12;
              state_q <= S_FETCH;
            end
            OP_JZ: begin
              if (acc_q == 16'h0000) pc_q <= addr12;
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end
            default: begin
              illegal_q <= 1'b1;
              halted_q  <= 1'b1;
              state_q   <= S_HALTED;
            end
          endcase
        end
        S_WB: begin
          acc_q   <= (op == OP_ALU) ? alu_wb_d : mem_rdata;
          state_q <= S_FETCH;
        end
        // An illegal opcode locks the core here until reset.
        S_HALTED: if (run && !illegal_q) begin
          halted_q <= 1'b0;
          state_q  <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
